// File: rtl/bp_cce_lite_req_responder.sv
// bp_cce_lite_req_responder
//
// Non-coherent home agent for the LCE request channel. It takes one LCE
// request at a time, issues the matching memory command, waits for the
// memory response and returns the LCE command that completes the request
// (a data fill, uncached data or uncached-store-done). There is no
// directory and no invalidation traffic, so this is only suitable for a
// single LCE or for I/O configurations.
//
// Ports
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset
//   cce_id_i         this CCE's id, used as src_id on LCE commands
//   lce_req_i/_v_i   packed LCE request, valid       (ready->valid)
//   lce_req_ready_o  request ready
//   mem_cmd_o/_v_o   packed memory command, valid    (ready->valid)
//   mem_cmd_ready_i  memory command ready
//   mem_resp_i/_v_i  packed memory response, valid   (valid->yumi)
//   mem_resp_yumi_o  memory response consumed
//   lce_cmd_o/_v_o   packed LCE command, valid       (ready->valid)
//   lce_cmd_ready_i  LCE command ready
//   busy_o           a transaction is in flight
module bp_cce_lite_req_responder #(
  parameter int cce_id_width_p    = 2,
  parameter int lce_id_width_p    = 2,
  parameter int paddr_width_p     = 32,
  parameter int lce_assoc_p       = 8,
  parameter int cce_block_width_p = 512,
  parameter int dword_width_p     = 64,
  parameter int block_width_p     = cce_block_width_p,
  localparam int lg_block_size_in_bytes_lp = $clog2(block_width_p / 8),
  localparam int lg_lce_assoc_lp = $clog2(lce_assoc_p),
  localparam int lce_cce_req_width_lp = cce_id_width_p + lce_id_width_p + 3 + 1
                                        + lg_lce_assoc_lp + 3 + paddr_width_p + dword_width_p,
  localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + lce_id_width_p
                                        + lg_lce_assoc_lp + block_width_p,
  localparam int lce_cmd_width_lp = lce_id_width_p + cce_id_width_p + 4 + lg_lce_assoc_lp
                                    + 3 + paddr_width_p + block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_id_width_p-1:0]       cce_id_i,
  input  logic [lce_cce_req_width_lp-1:0] lce_req_i,
  input  logic                            lce_req_v_i,
  output logic                            lce_req_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,
  output logic [lce_cmd_width_lp-1:0]     lce_cmd_o,
  output logic                            lce_cmd_v_o,
  input  logic                            lce_cmd_ready_i,
  output logic                            busy_o
);

  // LCE request message types
  localparam logic [2:0] e_lce_req_rd    = 3'd0;
  localparam logic [2:0] e_lce_req_wr    = 3'd1;
  localparam logic [2:0] e_lce_req_uc_rd = 3'd2;
  localparam logic [2:0] e_lce_req_uc_wr = 3'd3;

  // memory message types
  localparam logic [3:0] e_cce_mem_rd    = 4'd0;
  localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;

  // LCE command message types
  localparam logic [3:0] e_lce_cmd_uc_st_done = 4'd7;
  localparam logic [3:0] e_lce_cmd_data       = 4'd8;
  localparam logic [3:0] e_lce_cmd_uc_data    = 4'd9;

  // coherence states
  localparam logic [2:0] e_coh_i = 3'b000;
  localparam logic [2:0] e_coh_s = 3'b001;
  localparam logic [2:0] e_coh_e = 3'b010;
  localparam logic [2:0] e_coh_m = 3'b110;

  // sizes are encoded as log2(bytes), so a full block is lg_block_size
  localparam logic [2:0] block_size_lp = 3'(lg_block_size_in_bytes_lp);
  localparam logic [paddr_width_p-1:0] block_offset_mask_lp =
    paddr_width_p'((64'd1 << lg_block_size_in_bytes_lp) - 64'd1);

  typedef struct packed {
    logic [cce_id_width_p-1:0]  dst_id;
    logic [lce_id_width_p-1:0]  src_id;
    logic [2:0]                 msg_type;
    logic                       non_exclusive;
    logic [lg_lce_assoc_lp-1:0] lru_way_id;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [dword_width_p-1:0]   data;
  } lce_cce_req_s;

  typedef struct packed {
    logic [3:0]                 msg_type;
    logic [paddr_width_p-1:0]   addr;
    logic [2:0]                 size;
    logic [lce_id_width_p-1:0]  lce_id;
    logic [lg_lce_assoc_lp-1:0] way_id;
    logic [block_width_p-1:0]   data;
  } cce_mem_msg_s;

  typedef struct packed {
    logic [lce_id_width_p-1:0]  dst_id;
    logic [cce_id_width_p-1:0]  src_id;
    logic [3:0]                 msg_type;
    logic [lg_lce_assoc_lp-1:0] way_id;
    logic [2:0]                 state;
    logic [paddr_width_p-1:0]   addr;
    logic [block_width_p-1:0]   data;
  } lce_cmd_s;

  typedef enum logic [1:0] {
    e_reset        = 2'd0,
    e_ready        = 2'd1,
    e_send_mem_cmd = 2'd2,
    e_send_lce_cmd = 2'd3
  } state_e;

  state_e       state_r, state_next_s;
  lce_cce_req_s req_r, req_next_s, req_in_s;
  cce_mem_msg_s mem_cmd_s, mem_resp_s;
  lce_cmd_s     lce_cmd_s_s;
  logic         req_known_s;
  logic         unused_s;

  assign req_in_s   = lce_req_i;
  assign mem_resp_s = mem_resp_i;
  assign req_known_s = (req_in_s.msg_type <= e_lce_req_uc_wr);

  // fields of the response the LCE command does not need
  assign unused_s = ^{mem_resp_s.msg_type, mem_resp_s.size, mem_resp_s.lce_id,
                      mem_resp_s.way_id, req_r.dst_id};

  // state and captured request registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_reset;
      req_r   <= '0;
    end else begin
      state_r <= state_next_s;
      req_r   <= req_next_s;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    state_next_s    = state_r;
    req_next_s      = req_r;
    lce_req_ready_o = 1'b0;
    mem_cmd_v_o     = 1'b0;
    mem_resp_yumi_o = 1'b0;
    lce_cmd_v_o     = 1'b0;
    busy_o          = 1'b0;
    case (state_r)
      e_reset: begin
        state_next_s = e_ready;
      end
      e_ready: begin
        lce_req_ready_o = 1'b1;
        // unknown request types are consumed here and never reach memory
        if (lce_req_v_i && req_known_s) begin
          req_next_s   = req_in_s;
          state_next_s = e_send_mem_cmd;
        end else begin
          state_next_s = e_ready;
        end
      end
      e_send_mem_cmd: begin
        mem_cmd_v_o = 1'b1;
        busy_o      = 1'b1;
        if (mem_cmd_ready_i) begin
          state_next_s = e_send_lce_cmd;
        end else begin
          state_next_s = e_send_mem_cmd;
        end
      end
      e_send_lce_cmd: begin
        // response is passed straight through; it is only consumed when
        // the LCE command is accepted in the same cycle
        busy_o      = 1'b1;
        lce_cmd_v_o = mem_resp_v_i;
        if (mem_resp_v_i && lce_cmd_ready_i) begin
          mem_resp_yumi_o = 1'b1;
          state_next_s    = e_ready;
        end else begin
          state_next_s = e_send_lce_cmd;
        end
      end
      default: begin
        state_next_s = e_reset;
      end
    endcase
  end

  // memory command built from the captured request
  always_comb begin
    mem_cmd_s        = '0;
    mem_cmd_s.addr   = req_r.addr;
    mem_cmd_s.size   = req_r.size;
    mem_cmd_s.lce_id = req_r.src_id;
    mem_cmd_s.way_id = req_r.lru_way_id;
    case (req_r.msg_type)
      e_lce_req_rd, e_lce_req_wr: begin
        // cached writes allocate, so both fetch the whole aligned block
        mem_cmd_s.msg_type = e_cce_mem_rd;
        mem_cmd_s.addr     = req_r.addr & ~block_offset_mask_lp;
        mem_cmd_s.size     = block_size_lp;
      end
      e_lce_req_uc_rd: begin
        mem_cmd_s.msg_type = e_cce_mem_uc_rd;
      end
      e_lce_req_uc_wr: begin
        mem_cmd_s.msg_type                 = e_cce_mem_uc_wr;
        mem_cmd_s.data[dword_width_p-1:0] = req_r.data;
      end
      default: begin
        mem_cmd_s.msg_type = e_cce_mem_rd;
      end
    endcase
  end

  // LCE command built from the captured request and the memory response
  always_comb begin
    lce_cmd_s_s        = '0;
    lce_cmd_s_s.dst_id = req_r.src_id;
    lce_cmd_s_s.src_id = cce_id_i;
    lce_cmd_s_s.addr   = mem_resp_s.addr;
    lce_cmd_s_s.way_id = req_r.lru_way_id;
    lce_cmd_s_s.state  = e_coh_i;
    case (req_r.msg_type)
      e_lce_req_rd: begin
        lce_cmd_s_s.msg_type = e_lce_cmd_data;
        lce_cmd_s_s.state    = req_r.non_exclusive ? e_coh_s : e_coh_e;
        lce_cmd_s_s.data     = mem_resp_s.data;
      end
      e_lce_req_wr: begin
        lce_cmd_s_s.msg_type = e_lce_cmd_data;
        lce_cmd_s_s.state    = e_coh_m;
        lce_cmd_s_s.data     = mem_resp_s.data;
      end
      e_lce_req_uc_rd: begin
        lce_cmd_s_s.msg_type = e_lce_cmd_uc_data;
        lce_cmd_s_s.data     = mem_resp_s.data;
      end
      e_lce_req_uc_wr: begin
        lce_cmd_s_s.msg_type = e_lce_cmd_uc_st_done;
      end
      default: begin
        lce_cmd_s_s.msg_type = e_lce_cmd_uc_st_done;
      end
    endcase
  end

  assign mem_cmd_o = mem_cmd_s;
  assign lce_cmd_o = lce_cmd_s_s;

endmodule

// File: doc/bp_cce_lite_req_responder.md
Name: bp_cce_lite_req_responder

Overview:
- Home-side endpoint of the LCE request channel. Sits between the coherence NoC and the memory port.
- Accepts one LCE request at a time: cached read, cached write, uncached load, or uncached store.
- Issues the matching memory command, waits for the memory response, then returns the LCE command that completes the transaction. That command is what raises cache_req_complete or uc_store_req_complete back at the requesting LCE.
- Non-coherent "lite" home agent: no directory, no invalidations. Used for single-LCE or I/O configurations.

Parameters:
- bp_params_p, e_bp_inv_cfg: processor configuration. Supplies cce_id_width_p, lce_id_width_p, paddr_width_p, lce_assoc_p, cce_block_width_p, dword_width_p.
- block_width_p, cce_block_width_p: cached block size in bits. Sets the cached mem cmd size and the address alignment.
- lg_block_size_in_bytes_lp, derived: log2(block_width_p/8).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- cce_id_i  in  cce_id_width_p  this CCE's id, used as src_id on LCE commands.
- lce_req_i  in  lce_cce_req_width_lp  packed bp_lce_cce_req_s.
- lce_req_v_i  in  1  request valid.
- lce_req_ready_o  out  1  request ready (ready->valid).
- mem_cmd_o  out  cce_mem_msg_width_lp  packed bp_cce_mem_msg_s.
- mem_cmd_v_o  out  1  command valid.
- mem_cmd_ready_i  in  1  command ready (ready->valid).
- mem_resp_i  in  cce_mem_msg_width_lp  packed bp_cce_mem_msg_s.
- mem_resp_v_i  in  1  response valid.
- mem_resp_yumi_o  out  1  response consumed (valid->yumi).
- lce_cmd_o  out  lce_cmd_width_lp  packed bp_lce_cmd_s.
- lce_cmd_v_o  out  1  command valid.
- lce_cmd_ready_i  in  1  command ready (ready->valid).
- busy_o  out  1  a transaction is in flight.

Behaviour:
- Reset:
  - On reset_n_i low, state goes to e_reset asynchronously; request register cleared.
  - All outputs are 0 during and after reset: lce_req_ready_o, mem_cmd_v_o, mem_resp_yumi_o, lce_cmd_v_o, busy_o.
  - Reset asserted mid-transaction abandons the transaction; no further cmd or resp is issued for it.
- States: e_reset -> e_ready (unconditional, one cycle) -> e_send_mem_cmd -> e_send_lce_cmd -> e_ready.
- e_ready:
  - lce_req_ready_o = 1.
  - On lce_req_v_i, capture lce_req_i into req_r and go to e_send_mem_cmd.
  - Unknown msg_type: request is accepted and dropped; stay in e_ready.
- e_send_mem_cmd:
  - mem_cmd_v_o = 1; transition when mem_cmd_ready_i = 1.
  - mem_cmd fields:
    - rd, wr, uc_rd: msg_type e_cce_mem_rd (uc_rd uses e_cce_mem_uc_rd).
    - uc_wr: msg_type e_cce_mem_uc_wr, data[dword_width_p-1:0] taken from req_r.
    - Cached addr: req_r.addr with the low lg_block_size_in_bytes_lp bits zeroed; size = block size.
    - Uncached addr and size: copied unchanged.
    - payload.lce_id = req_r.src_id; payload.way_id = req_r.lru_way_id.
- e_send_lce_cmd:
  - lce_cmd_v_o = mem_resp_v_i. When lce_cmd_ready_i is also 1, mem_resp_yumi_o = 1 in the same cycle, then go to e_ready.
  - Single-cycle pass-through; no response buffering.
  - lce_cmd fields:
    - dst_id = req_r.src_id; src_id = cce_id_i; addr = mem_resp.addr; way_id = req_r.lru_way_id.
    - rd: e_lce_cmd_data; state e_COH_S if non_exclusive else e_COH_E.
    - wr: e_lce_cmd_data, state e_COH_M.
    - uc_rd: e_lce_cmd_uc_data; data = mem_resp data.
    - uc_wr: e_lce_cmd_uc_st_done; data = 0.
- mem_resp_v_i outside e_send_lce_cmd: never yumi'd. Response stays pending.
- busy_o = 1 in e_send_mem_cmd and e_send_lce_cmd.
- Throughput: one transaction at a time. Minimum request-to-command latency is 2 cycles: accept in cycle 0, mem cmd in cycle 1, LCE cmd in cycle 2 with the response already valid. lce_req_ready_o is 0 until the cycle after the LCE cmd handshake.
- No combinational path from lce_req_v_i to any output.

Test Plan:
- Cached read, non_exclusive=1, addr 0x8000_1234, 64B block -> mem cmd rd addr 0x8000_1200, size 64. After response: lce_cmd e_lce_cmd_data, state S, dst_id = requester.
- Cached write, lru_way_id 3 -> lce_cmd state M, way_id 3. Repeat with non_exclusive=0 on a read -> state E.
- Uncached store, size 8, data 0xDEAD_BEEF -> mem cmd uc_wr carries that data at the unmodified addr. Response -> lce_cmd uc_st_done, data 0.
- Backpressure: mem_cmd_ready_i low 5 cycles, then lce_cmd_ready_i low 3 cycles with mem_resp_v_i high -> mem_cmd_v_o holds stable, yumi only in the handshake cycle, no second request accepted (lce_req_ready_o 0 throughout).
- Back-to-back uncached load pair with immediate ready/valid -> LCE cmds in cycles 2 and 5 relative to the first accept; data returned in order.
- reset_n_i pulsed low while in e_send_lce_cmd -> all outputs 0 immediately. After release: e_reset, then e_ready with lce_req_ready_o=1 on the second cycle; the stale mem response is not consumed.
